// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC arbiter slice.
package cordic_pkg;

  localparam int CORDIC_W       = 32;
  localparam int CORDIC_LAT     = 16;
  localparam int CORDIC_IDW_MAX = 3;

  // 45 degrees in z units (radians scaled by 2^20)
  localparam logic [CORDIC_W-1:0] ANG_45 = 32'd823549;

  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

  typedef struct packed {
    logic                mode;
    logic [CORDIC_W-1:0] x;
    logic [CORDIC_W-1:0] y;
    logic [CORDIC_W-1:0] z;
  } cordic_op_t;

  typedef struct packed {
    logic                      valid;
    logic [CORDIC_IDW_MAX-1:0] id;
  } cordic_tag_t;

  // Round-robin successor of idx among n slots
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr.
// Purely combinational; the pointer register lives with the user.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic            en,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  logic [IDW-1:0] scan;
  logic           found;

  // Scan NREQ slots starting at ptr, first valid request wins
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    scan    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = IDW'((int'(ptr) + k) % NREQ);
      if (en && !found && req[scan]) begin
        gnt[scan] = 1'b1;
        gnt_idx   = scan;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one pipelined CORDIC core between NREQ requesters.
// Round-robin issue into registered core inputs, tag pipeline tracks
// requester IDs through the core latency. Optional perf counters are
// built when CORDIC_ARB_PERF_EN is defined.
module cordic_arbiter
  import cordic_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = CORDIC_W,
  parameter int LAT  = CORDIC_LAT,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_mode,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  input  logic [NREQ*W-1:0] req_z,
  output logic              cor_mode,
  output logic [W-1:0]      cor_x_i,
  output logic [W-1:0]      cor_y_i,
  output logic [W-1:0]      cor_z_i,
  input  logic [W-1:0]      cor_x_o,
  input  logic [W-1:0]      cor_y_o,
  input  logic [W-1:0]      cor_z_o,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_x,
  output logic [W-1:0]      rsp_y,
  output logic [W-1:0]      rsp_z,
  output logic              busy
`ifdef CORDIC_ARB_PERF_EN
  ,
  output logic [NREQ*16-1:0] perf_grant_cnt,
  output logic [31:0]        perf_busy_cnt
`endif
);

  logic [IDW-1:0]          ptr;
  logic [NREQ-1:0]         gnt;
  logic [IDW-1:0]          gnt_idx;
  logic                    hs;
  cordic_op_t              sel_op;
  cordic_op_t              cor_op;
  logic [LAT:0]            vld_pipe;
  logic [LAT:0][IDW-1:0]   id_pipe;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req     (req_valid),
    .en      (en),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Grants only go to valid requesters, so any grant is a handshake
  assign req_ready = gnt;
  assign hs        = |(req_valid & gnt);

  // Operand mux for the granted requester
  always_comb begin
    sel_op      = '0;
    sel_op.mode = req_mode[gnt_idx];
    sel_op.x    = req_x[int'(gnt_idx)*W +: W];
    sel_op.y    = req_y[int'(gnt_idx)*W +: W];
    sel_op.z    = req_z[int'(gnt_idx)*W +: W];
  end

  // Round-robin pointer moves past the winner on each handshake
  always_ff @(posedge clk) begin
    if (rst)     ptr <= '0;
    else if (hs) ptr <= IDW'(rr_next(int'(gnt_idx), NREQ));
  end

  // Core input register; idle cycles feed zeros
  always_ff @(posedge clk) begin
    if (rst) cor_op <= '0;
    else     cor_op <= hs ? sel_op : '0;
  end

  assign cor_mode = cor_op.mode;
  assign cor_x_i  = cor_op.x;
  assign cor_y_i  = cor_op.y;
  assign cor_z_i  = cor_op.z;

  // Tag pipeline, LAT+1 stages, never stalls. Stage-0 id holds on idle
  // cycles so bubbles carry the previous op's id and rsp_id holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[LAT-1:0], hs};
      id_pipe  <= {id_pipe[LAT-1:0], (hs ? gnt_idx : id_pipe[0])};
    end
  end

  assign rsp_valid = vld_pipe[LAT];
  assign rsp_id    = id_pipe[LAT];
  assign rsp_x     = cor_x_o;
  assign rsp_y     = cor_y_o;
  assign rsp_z     = cor_z_o;
  assign busy      = |vld_pipe;

`ifdef CORDIC_ARB_PERF_EN
  logic [NREQ-1:0][15:0] grant_cnt;
  logic [31:0]           busy_cnt;

  // Saturating per-requester handshake counters
  always_ff @(posedge clk) begin
    if (rst) grant_cnt <= '0;
    else begin
      for (int i = 0; i < NREQ; i++)
        if (gnt[i] && req_valid[i] && grant_cnt[i] != 16'hFFFF)
          grant_cnt[i] <= grant_cnt[i] + 16'd1;
    end
  end

  // Wrapping count of busy cycles
  always_ff @(posedge clk) begin
    if (rst)       busy_cnt <= '0;
    else if (busy) busy_cnt <= busy_cnt + 32'd1;
  end

  assign perf_grant_cnt = grant_cnt;
  assign perf_busy_cnt  = busy_cnt;
`endif

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter with an ideal CORDIC core model.
module tb_cordic_arbiter;
  import cordic_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int LAT  = 16;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en  = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_mode = '0;
  logic [NREQ*W-1:0] req_x = '0, req_y = '0, req_z = '0;
  logic              cor_mode;
  logic [W-1:0]      cor_x_i, cor_y_i, cor_z_i;
  logic [W-1:0]      cor_x_o, cor_y_o, cor_z_o;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_x, rsp_y, rsp_z;
  logic              busy;
`ifdef CORDIC_ARB_PERF_EN
  logic [NREQ*16-1:0] perf_grant_cnt;
  logic [31:0]        perf_busy_cnt;
`endif

  cordic_arbiter #(.NREQ(NREQ), .W(W), .LAT(LAT), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .cor_mode(cor_mode), .cor_x_i(cor_x_i), .cor_y_i(cor_y_i), .cor_z_i(cor_z_i),
    .cor_x_o(cor_x_o), .cor_y_o(cor_y_o), .cor_z_o(cor_z_o),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z),
    .busy(busy)
`ifdef CORDIC_ARB_PERF_EN
    , .perf_grant_cnt(perf_grant_cnt), .perf_busy_cnt(perf_busy_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  // Ideal CORDIC core (gain included), LAT-deep output delay
  function automatic cordic_op_t core_ref(input logic m, input logic [31:0] x,
                                          input logic [31:0] y, input logic [31:0] z);
    cordic_op_t r;
    real k, s, rx, ry, a;
    k  = 1.646760258;
    s  = 1048576.0;
    rx = $itor($signed(x));
    ry = $itor($signed(y));
    a  = $itor($signed(z)) / s;
    r.mode = m;
    if (m == MODE_ROT) begin
      r.x = $rtoi(k * (rx * $cos(a) - ry * $sin(a)));
      r.y = $rtoi(k * (ry * $cos(a) + rx * $sin(a)));
      r.z = '0;
    end else begin
      r.x = $rtoi(k * $sqrt(rx * rx + ry * ry));
      r.y = '0;
      r.z = $rtoi($itor($signed(z)) + $atan2(ry, rx) * s);
    end
    return r;
  endfunction

  cordic_op_t mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= core_ref(cor_mode, cor_x_i, cor_y_i, cor_z_i);
    for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign cor_x_o = mpipe[LAT-1].x;
  assign cor_y_o = mpipe[LAT-1].y;
  assign cor_z_o = mpipe[LAT-1].z;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected responses: due cycle and requester id
  typedef struct { int due; int id; } exp_t;
  exp_t q[$];
  int   last_id  = 0;
  int   last_due = 0;
  int   busy_exp_cnt = 0;
  bit   mon_en   = 1'b0;

  // Response/busy monitor, every cycle
  always @(negedge clk) begin
    bit ev, eb;
    if (mon_en && !rst) begin
      ev = (q.size() > 0) && (q[0].due == cyc);
      eb = 1'b0;
      foreach (q[i]) if (q[i].due - LAT <= cyc) eb = 1'b1;
      check("rsp_valid", rsp_valid, ev);
      check("busy", busy, eb);
      if (ev) begin
        last_id = q[0].id;
        void'(q.pop_front());
      end
      check("rsp_id", rsp_id, last_id);
      if (eb) busy_exp_cnt++;
    end
  end

  // One cycle: check ready at negedge, record expected response, cross edge
  task automatic step(input logic [NREQ-1:0] exp_rdy, input string tag);
    @(negedge clk);
    check(tag, req_ready, exp_rdy);
    for (int i = 0; i < NREQ; i++)
      if (exp_rdy[i]) begin
        last_due = cyc + LAT + 1;
        q.push_back('{last_due, i});
      end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    q.delete();
    last_id = 0;
    busy_exp_cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int gi;
    int dx;
    logic [31:0] obs;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    en  = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_busy", busy, 0);
    check("rst_cor_x", cor_x_i, 0);
    check("rst_cor_mode", cor_mode, 0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Single rotation by 45 degrees on requester 0
    req_mode[0]     = MODE_ROT;
    req_x[0 +: W]   = 32'd636751;
    req_y[0 +: W]   = 32'd0;
    req_z[0 +: W]   = ANG_45;
    req_valid       = 4'b0001;
    step(4'b0001, "t1_ready");
    req_valid = '0;
    @(negedge clk);
    check("t1_cor_x", cor_x_i, 636751);
    check("t1_cor_y", cor_y_i, 0);
    check("t1_cor_z", cor_z_i, 823549);
    check("t1_cor_mode", cor_mode, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t1_cor_idle", cor_x_i, 0);
    while (cyc < last_due) @(negedge clk);
    dx  = $signed(rsp_x) - 741455;
    obs = (dx >= -16 && dx <= 16) ? 32'd741455 : rsp_x;
    check("t1_rsp_x", obs, 741455);
    dx  = $signed(rsp_y) - 741455;
    obs = (dx >= -16 && dx <= 16) ? 32'd741455 : rsp_y;
    check("t1_rsp_y", obs, 741455);
    check("t1_rsp_z", rsp_z, 0);
    @(posedge clk);
    #1;
    idle(4);

    // Full load from reset: 0,1,2,3,... no bubbles
    pulse_rst();
    req_valid = 4'hF;
    for (int k = 0; k < 20; k++) step(4'(1 << (k % 4)), "t2_ready");
    req_valid = '0;
    idle(20);

    // Pointer to 2 via a grant to 1, then only 1 and 3 valid
    req_valid = 4'b0010;
    step(4'b0010, "t3_ready_pre");
    req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) step((k % 2 == 0) ? 4'b1000 : 4'b0010, "t3_ready");
    req_valid = '0;
    idle(20);

    // en low for 5 cycles under full load
    pulse_rst();
    req_valid = 4'hF;
    gi = 0;
    for (int k = 0; k < 25; k++) begin
      en = !(k >= 10 && k <= 14);
      if (en) begin
        step(4'(1 << (gi % 4)), "t4_ready");
        gi++;
      end else begin
        step(4'b0000, "t4_ready_off");
      end
    end
    req_valid = '0;
    en = 1'b1;
    idle(20);

    // Reset mid-flight discards results and restarts the pointer
    pulse_rst();
    req_valid = 4'b0111;
    step(4'b0001, "t5_ready");
    step(4'b0010, "t5_ready");
    step(4'b0100, "t5_ready");
    step(4'b0001, "t5_ready");
    req_valid = '0;
    idle(8);
    pulse_rst();
    @(negedge clk);
    check("t5_busy_after_rst", busy, 0);
    check("t5_vld_after_rst", rsp_valid, 0);
    @(posedge clk);
    #1;
    idle(20);
    req_valid = 4'hF;
    step(4'b0001, "t5_ptr0");
    req_valid = '0;
    idle(20);

`ifdef CORDIC_ARB_PERF_EN
    // Saturation of the grant counter and busy cycle count
    pulse_rst();
    req_valid = 4'b0100;
    for (int k = 0; k < 70000; k++) step(4'b0100, "perf_ready");
    req_valid = '0;
    idle(20);
    check("perf_grant2", perf_grant_cnt[2*16 +: 16], 65535);
    check("perf_grant0", perf_grant_cnt[0 +: 16], 0);
    check("perf_busy", perf_busy_cnt, busy_exp_cnt);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_arbiter.md
Name: cordic_arbiter

Overview:
- Shares one 16-stage pipelined CORDIC core (cordic_32_16: mode/x/y/z in, x/y/z out, one result per clock) between NREQ requesters.
- Round-robin grant, at most one issue per clock, valid/ready per requester.
- Registers each issued operand set into the core and tracks it with a tag pipeline matched to core latency.
- Presents each core result with the issuing requester's ID; no backpressure on the response side.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 32, operand/result width; equals core width.
- LAT, 16, core latency in clocks from registered input to output.
- IDW, $clog2(NREQ), requester ID width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- en  in  1  issue enable; low blocks new grants, in-flight ops drain.
- req_valid  in  NREQ  request valid per requester.
- req_ready  out  NREQ  grant/accept per requester.
- req_mode  in  NREQ  CORDIC mode bit per requester.
- req_x / req_y / req_z  in  NREQ*W each  operands, requester i at bits [i*W +: W].
- cor_mode  out  1  to core mode.
- cor_x_i / cor_y_i / cor_z_i  out  W each  to core inputs, registered.
- cor_x_o / cor_y_o / cor_z_o  in  W each  from core outputs.
- rsp_valid  out  1  result valid.
- rsp_id  out  IDW  requester ID of result.
- rsp_x / rsp_y / rsp_z  out  W each  result, pass-through of cor_*_o.
- busy  out  1  any op in flight.

Behaviour:
- Reset: all tag valids 0; cor_* = 0; rsp_valid = 0; rsp_id = 0; busy = 0; RR pointer = 0. Reset mid-operation discards all in-flight results. Core contents are not cleared, but tags are, so no stale rsp_valid appears.
- Grant (combinational from registered pointer):
  - When en = 1 and any req_valid is set, grant the first valid index at or after the pointer, modulo NREQ.
  - req_ready is one-hot or zero. It never depends on its own valid except through arbitration.
- Handshake: req_valid[i] & req_ready[i] at a rising edge.
- On handshake:
  - Load cor_mode/cor_x_i/cor_y_i/cor_z_i from requester i.
  - Tag stage 0 gets valid = 1, id = i.
  - Pointer becomes (i+1) mod NREQ.
- No handshake: cor_* inputs load 0, tag stage 0 valid = 0, pointer unchanged.
- Tag pipeline: LAT+1 stages of {valid, id}, shifting every clock with no stall.
- Latency:
  - Handshake in cycle t gives rsp_valid = 1 in cycle t+1+LAT (t+17 at default).
  - rsp_x/y/z are the core outputs in that cycle.
- rsp_id and rsp_valid come from the last tag stage. rsp_id holds its last value when rsp_valid = 0.
- Throughput: one op/clock sustained. Ordering is FIFO across all requesters.
- busy = OR of all tag valids.
- en falling mid-stream: no new grants from that cycle; in-flight results still emerge.
- NREQ = 1 degenerates to pass-through: ready = valid & en.
- Requesters must hold operands stable while valid and not ready.

Optional Feature:
- Macro: CORDIC_ARB_PERF_EN.
- Defined:
  - Adds output perf_grant_cnt (NREQ*16): per-requester 16-bit saturating counts of handshakes.
  - Adds output perf_busy_cnt (32): wrapping count of cycles with busy = 1.
  - Both counters clear on rst.
- Undefined: both ports absent. No counter logic.

Decomposition:
- Package cordic_pkg:
  - CORDIC_W = 32, CORDIC_LAT = 16.
  - Typedef cordic_op_t {mode, x, y, z}.
  - Typedef cordic_tag_t {valid, id}.
  - Angle constant ANG_45 = 823549 (z scaled 2^20 rad).
- Sub-module rr_arbiter (NREQ):
  - Inputs: request vector, en, pointer.
  - Outputs: one-hot grant, grant index.
  - Reused elsewhere for shared arithmetic cores.

Test Plan:
- Single op:
  - Stimulus: req 0, mode rotation, x = 636751, y = 0, z = 823549, handshake at cycle 5, core model attached.
  - Expected: rsp_valid only in cycle 22, rsp_id = 0, rsp_x ≈ rsp_y ≈ 741455 ±16 LSB.
- All four requesters valid continuously for 20 cycles from reset:
  - Grants go 0,1,2,3,0,… with one grant per cycle.
  - rsp_id sequence matches grant sequence, shifted 17 cycles.
  - No bubbles.
- Only requesters 1 and 3 valid, pointer at 2:
  - Grant order 3,1,3,1.
  - req_ready[0] and req_ready[2] never high.
- en low for cycles 10–14 under full load:
  - No handshakes in cycles 10–14.
  - rsp_valid is low exactly in cycles 27–31.
  - busy stays high until the last result.
- rst pulsed one cycle, 8 cycles after a burst of 4 ops:
  - No rsp_valid appears afterward.
  - busy = 0 the cycle after reset.
  - Pointer restarts at 0.
- With CORDIC_ARB_PERF_EN, 70000 grants to requester 2:
  - perf_grant_cnt[2] saturates at 65535.
  - perf_busy_cnt equals the cycle count with busy = 1.
